// File: rtl/norm_pkg.sv
// Shared types, default parameters and helpers for the seq_normalizer block.
package norm_pkg;

  localparam int unsigned NORM_N_CH = 8;
  localparam int unsigned NORM_DW   = 16;
  localparam int unsigned NORM_FRAC = 8;
  localparam int unsigned NORM_OW   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUB,
    S_DIV,
    S_STORE,
    S_OUT
  } norm_state_e;

  // Calibrated glove-sensor coefficients that the integration level drives onto i_mean/i_std.
  function automatic logic [NORM_DW-1:0] glove_mean(input int unsigned ch);
    case (ch)
      0:       return 16'h0305;
      1:       return 16'h02F0;
      2:       return 16'h0312;
      3:       return 16'h0300;
      4:       return 16'h02E8;
      5:       return 16'h0320;
      6:       return 16'h02FA;
      default: return 16'h0308;
    endcase
  endfunction

  function automatic logic [NORM_DW-1:0] glove_std(input int unsigned ch);
    case (ch)
      0:       return 16'h01F1;
      1:       return 16'h01E0;
      2:       return 16'h0200;
      3:       return 16'h01F8;
      4:       return 16'h01D0;
      5:       return 16'h0210;
      6:       return 16'h01E8;
      default: return 16'h01F4;
    endcase
  endfunction

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/norm_divider.sv
// Serial restoring unsigned divider: one quotient bit per cycle, MSB first.
module norm_divider #(
  parameter int unsigned NW  = 25,
  parameter int unsigned DVW = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [NW-1:0]  i_dividend,
  input  logic [DVW-1:0] i_divisor,
  output logic [NW-1:0]  o_quotient,
  output logic           o_done_c
);

  localparam int unsigned CW = $clog2(NW + 1);

  logic           run_q, run_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NW-1:0]  dvd_q, dvd_d;
  logic [DVW-1:0] dvs_q, dvs_d;
  logic [DVW-1:0] rem_q, rem_d;
  logic [NW-1:0]  quot_q, quot_d;
  logic [DVW:0]   rem_sh;
  logic [DVW:0]   rem_sub;
  logic           qbit;

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  // Shift in the next dividend bit; subtract when the partial remainder covers the divisor.
  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    rem_sh  = {rem_q, dvd_q[NW-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    qbit    = (rem_sh >= {1'b0, dvs_q});

    if (i_start) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      dvd_d  = i_dividend;
      dvs_d  = i_divisor;
      rem_d  = '0;
      quot_d = '0;
    end else if (run_q) begin
      rem_d  = qbit ? rem_sub[DVW-1:0] : rem_sh[DVW-1:0];
      quot_d = {quot_q[NW-2:0], qbit};
      dvd_d  = dvd_q << 1;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == CW'(NW - 1)) run_d = 1'b0;
    end
  end

  assign o_quotient = quot_q;
  assign o_done_c   = run_q && (cnt_q == CW'(NW - 1));

endmodule

// File: rtl/seq_normalizer.sv
// Per-channel z-score normalizer sharing one serial divider across channels.
// Build option NORM_ROUND_EN: round half away from zero instead of truncating.
module seq_normalizer
  import norm_pkg::*;
#(
  parameter int unsigned N_CH = NORM_N_CH,
  parameter int unsigned DW   = NORM_DW,
  parameter int unsigned FRAC = NORM_FRAC,
  parameter int unsigned OW   = NORM_OW
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [N_CH-1:0][DW-1:0]  i_data,
  input  logic [N_CH-1:0][DW-1:0]  i_mean,
  input  logic [N_CH-1:0][DW-1:0]  i_std,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [N_CH-1:0][OW-1:0]  o_norm,
  output logic                     o_busy
);

`ifdef NORM_ROUND_EN
  localparam int unsigned SH = FRAC + 1;
`else
  localparam int unsigned SH = FRAC;
`endif
  localparam int unsigned QB  = DW + 1 + SH;
  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  norm_state_e               state_q, state_d;
  logic [CHW-1:0]            ch_q, ch_d;
  logic                      sign_q, sign_d;
  logic                      zero_q, zero_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic [N_CH-1:0][DW-1:0]   data_q, data_d;
  logic [N_CH-1:0][DW-1:0]   mean_q, mean_d;
  logic [N_CH-1:0][DW-1:0]   std_q, std_d;
  logic [N_CH-1:0][OW-1:0]   norm_q, norm_d;

  logic signed [DW:0]        diff;
  logic [DW:0]               mag;
  logic                      div_start;
  logic [QB-1:0]             div_dividend;
  logic [QB-1:0]             div_quot;
  logic                      div_done_c;
  logic [QB-1:0]             mag_fin;
  logic signed [63:0]        res;
  logic signed [63:0]        res_sat;

  norm_divider #(
    .NW  (QB),
    .DVW (DW)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (div_start),
    .i_dividend (div_dividend),
    .i_divisor  (std_q[ch_q]),
    .o_quotient (div_quot),
    .o_done_c   (div_done_c)
  );

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      mean_q  <= '0;
      std_q   <= '0;
      norm_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      mean_q  <= mean_d;
      std_q   <= std_d;
      norm_q  <= norm_d;
    end
  end

  // Sign-extended difference of the current channel and the scaled dividend.
  always_comb begin
    diff = $signed({data_q[ch_q][DW-1], data_q[ch_q]})
         - $signed({mean_q[ch_q][DW-1], mean_q[ch_q]});
    mag  = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
    div_dividend = {mag, {SH{1'b0}}};
  end

  // Final magnitude, signed result and saturation for the S_STORE write.
  always_comb begin
`ifdef NORM_ROUND_EN
    mag_fin = QB'(({1'b0, div_quot} + (QB + 1)'(1)) >> 1);
`else
    mag_fin = div_quot;
`endif
    if (std_q[ch_q] == '0) begin
      if (zero_q)      res = 64'sd0;
      else if (sign_q) res = -(64'sd1 <<< 62);
      else             res = 64'sd1 <<< 62;
    end else begin
      res = sign_q ? -$signed(64'(mag_fin)) : $signed(64'(mag_fin));
    end
    res_sat = sat_signed(res, OW);
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sign_d    = sign_q;
    zero_d    = zero_q;
    data_d    = data_q;
    mean_d    = mean_q;
    std_d     = std_q;
    norm_d    = norm_q;
    div_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          data_d  = i_data;
          mean_d  = i_mean;
          std_d   = i_std;
          ch_d    = '0;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        sign_d    = diff[DW];
        zero_d    = (diff == '0);
        div_start = 1'b1;
        state_d   = S_DIV;
      end
      S_DIV: begin
        if (div_done_c) state_d = S_STORE;
      end
      S_STORE: begin
        norm_d[ch_q] = OW'(res_sat);
        if (ch_q == CHW'(N_CH - 1)) begin
          state_d = S_OUT;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = S_SUB;
        end
      end
      S_OUT: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_OUT);
    busy_d  = (state_d != S_IDLE);
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_norm  = norm_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: randomized and directed samples against an arithmetic model.
`timescale 1ns/1ps
module tb_seq_normalizer;

  localparam int unsigned N_CH = 8;
  localparam int unsigned DW   = 16;
  localparam int unsigned FRAC = 8;
  localparam int unsigned OW   = 16;
  localparam int unsigned Q    = DW + 1 + FRAC;
`ifdef NORM_ROUND_EN
  localparam longint LAT = N_CH * (Q + 3);
`else
  localparam longint LAT = N_CH * (Q + 2);
`endif
  localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OW - 1));

  typedef logic [N_CH-1:0][DW-1:0] vin_t;
  typedef logic [N_CH-1:0][OW-1:0] vout_t;

  logic  i_clk = 1'b0;
  logic  i_rst_n;
  logic  i_valid;
  logic  o_ready;
  vin_t  i_data, i_mean, i_std;
  logic  o_valid;
  logic  i_ready;
  vout_t o_norm;
  logic  o_busy;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  vout_t  exp_q[$];
  longint acc_q[$];
  logic   prev_valid = 1'b0;

  seq_normalizer dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_mean  (i_mean),
    .i_std   (i_std),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_norm  (o_norm),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // z = (d - m) / s in fixed point, computed on plain integers.
  function automatic logic [OW-1:0] model(input logic [DW-1:0] d, input logic [DW-1:0] m,
                                          input logic [DW-1:0] s);
    longint diff, mag, sl, q, r;
    diff = longint'($signed(d)) - longint'($signed(m));
    mag  = (diff < 0) ? -diff : diff;
    sl   = longint'(s);
    if (sl == 0) begin
      r = (diff == 0) ? 0 : ((diff > 0) ? OMAX : OMIN);
    end else begin
`ifdef NORM_ROUND_EN
      q = (2 * mag * (64'sd1 <<< FRAC) + sl) / (2 * sl);
`else
      q = (mag * (64'sd1 <<< FRAC)) / sl;
`endif
      r = (diff < 0) ? -q : q;
      if (r > OMAX) r = OMAX;
      if (r < OMIN) r = OMIN;
    end
    return OW'(r);
  endfunction

  // Present a sample once o_ready is seen, push its expectation, return the accept cycle.
  task automatic send(input vin_t d, input vin_t m, input vin_t s, input vout_t e,
                      output longint acc);
    int n = 0;
    acc = -1;
    @(negedge i_clk);
    while (!o_ready && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      fail_now("send_ready");
      return;
    end
    i_data  = d;
    i_mean  = m;
    i_std   = s;
    i_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    acc = cyc;
    acc_q.push_back(acc);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now(name);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // Monitor: latency on the rising o_valid, result compare on each output handshake.
  always @(negedge i_clk) begin
    if (i_rst_n == 1'b0) begin
      if (o_valid && !prev_valid) begin
        if (acc_q.size() == 0) fail_now("unexpected_valid");
        else chk("latency", cyc - acc_q[0], LAT);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          vout_t e;
          e = exp_q.pop_front();
          if (acc_q.size() != 0) void'(acc_q.pop_front());
          for (int c = 0; c < N_CH; c++)
            chk($sformatf("norm_ch%0d", c), longint'(o_norm[c]), longint'(e[c]));
        end
      end
      prev_valid = o_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    vin_t   d, m, s;
    vout_t  e;
    longint acc, t0;
    int     n;

    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    i_mean  = '0;
    i_std   = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_ready", longint'(o_ready), 1);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_norm", longint'(o_norm), 0);
    i_rst_n = 1'b0;

    // Unit case: diff equals std on every channel.
    for (int c = 0; c < N_CH; c++) begin
      d[c] = 16'h04F6; m[c] = 16'h0305; s[c] = 16'h01F1; e[c] = 16'h0100;
    end
    send(d, m, s, e, acc);
    drain("unit_drain");

    for (int c = 0; c < N_CH; c++) begin
      d[c] = 16'h0114; m[c] = 16'h0305; s[c] = 16'h01F1; e[c] = 16'hFF00;
    end
    send(d, m, s, e, acc);
    drain("neg_drain");

    for (int c = 0; c < N_CH; c++) begin
      d[c] = 16'h0000; m[c] = 16'h0000; s[c] = 16'h0005; e[c] = 16'h0000;
    end
    send(d, m, s, e, acc);
    drain("zero_drain");

    // Saturation, zero divisor and rounding corners, one per channel.
    d[0] = 16'h7FFF; m[0] = 16'h0000; s[0] = 16'h0001; e[0] = 16'h7FFF;
    d[1] = 16'h8000; m[1] = 16'h0000; s[1] = 16'h0001; e[1] = 16'h8000;
    d[2] = 16'h0005; m[2] = 16'h0002; s[2] = 16'h0000; e[2] = 16'h7FFF;
    d[3] = 16'h0002; m[3] = 16'h0005; s[3] = 16'h0000; e[3] = 16'h8000;
    d[4] = 16'h1234; m[4] = 16'h1234; s[4] = 16'h0000; e[4] = 16'h0000;
    d[5] = 16'h0007; m[5] = 16'h0005; s[5] = 16'h0003;
    d[6] = 16'h0005; m[6] = 16'h0007; s[6] = 16'h0003;
    d[7] = 16'h8000; m[7] = 16'h7FFF; s[7] = 16'h0001; e[7] = 16'h8000;
`ifdef NORM_ROUND_EN
    e[5] = 16'h00AB; e[6] = 16'hFF55;
`else
    e[5] = 16'h00AA; e[6] = 16'hFF56;
`endif
    send(d, m, s, e, acc);
    drain("corner_drain");

    // Backpressure: hold i_ready low with o_valid up, pulse i_valid, then release.
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      d[c] = 16'($urandom); m[c] = 16'($urandom); s[c] = 16'($urandom_range(1, 400));
      e[c] = model(d[c], m[c], s[c]);
    end
    send(d, m, s, e, acc);
    n = 0;
    @(negedge i_clk);
    while (!o_valid && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_valid) fail_now("bp_valid");
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid_hold", longint'(o_valid), 1);
      chk("bp_ready_low", longint'(o_ready), 0);
      if (exp_q.size() != 0) chk("bp_norm_hold", longint'(o_norm), longint'(exp_q[0]));
      i_data  = vin_t'({$urandom, $urandom, $urandom, $urandom});
      i_valid = k[0];
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    @(posedge i_clk);
    #1 i_ready = 1'b1;
    t0 = cyc;
    for (int c = 0; c < N_CH; c++) begin
      d[c] = 16'h04F6; m[c] = 16'h0305; s[c] = 16'h01F1; e[c] = 16'h0100;
    end
    send(d, m, s, e, acc);
    chk("bp_next_accept", acc - t0, 2);
    drain("bp_drain");

    // Reset in the middle of channel 3's division.
    send(d, m, s, e, acc);
    repeat (3 * (LAT / N_CH) + 10) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    #1;
    chk("midrst_valid", longint'(o_valid), 0);
    chk("midrst_norm", longint'(o_norm), 0);
    chk("midrst_ready", longint'(o_ready), 1);
    chk("midrst_busy", longint'(o_busy), 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      d[c] = 16'h0007; m[c] = 16'h0005; s[c] = 16'h0003; e[c] = model(d[c], m[c], s[c]);
    end
    send(d, m, s, e, acc);
    drain("postrst_drain");

    // Randomized samples against the model.
    for (int t = 0; t < 14; t++) begin
      for (int c = 0; c < N_CH; c++) begin
        d[c] = 16'($urandom);
        m[c] = ($urandom_range(0, 3) == 0) ? d[c] : 16'($urandom);
        case ($urandom_range(0, 3))
          0:       s[c] = 16'h0000;
          1:       s[c] = 16'($urandom_range(1, 16));
          default: s[c] = 16'($urandom);
        endcase
        e[c] = model(d[c], m[c], s[c]);
      end
      send(d, m, s, e, acc);
    end
    drain("rand_drain");

    repeat (5) @(posedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_normalizer.md
Name: seq_normalizer

Overview:
Per-channel z-score normalizer, generalised to N_CH channels: o_norm[c] = (i_data[c] - i_mean[c]) / i_std[c] as signed fixed point with FRAC fractional bits.
- Runtime coefficients are sampled at accept, replacing hard-wired constants.
- A single shared serial divider serves all channels; multi-cycle latency is traded for area.
- A valid/ready handshake is used on both sides.
- Sits between the sensor sample collector and the classifier front end.

Parameters:
N_CH, 8, number of channels
DW, 16, width of i_data / i_mean (signed) and i_std (unsigned)
FRAC, 8, fractional bits of the output
OW, 16, output width (signed fixed point, FRAC fractional bits)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-high (despite the name)
i_valid  in  1  input sample valid
o_ready  out  1  block can accept a sample
i_data  in  N_CH x DW  signed raw samples
i_mean  in  N_CH x DW  signed per-channel mean
i_std  in  N_CH x DW  unsigned per-channel std
o_valid  out  1  o_norm valid
i_ready  in  1  downstream accepts o_norm
o_norm  out  N_CH x OW  signed normalized results
o_busy  out  1  high in every state except S_IDLE

Behaviour:
- Reset (async, i_rst_n=1):
  - state = S_IDLE, channel counter = 0.
  - o_valid = 0, o_busy = 0, o_norm all 0, all captured registers 0.
  - o_ready = 1 (combinational from S_IDLE).
- Accept: a transfer occurs on the rising edge where i_valid && o_ready. All of i_data, i_mean and i_std are captured into internal arrays on that edge. Later changes on these inputs are ignored.
- States:
  - S_IDLE: o_ready = 1. On accept, go to S_SUB with ch = 0.
  - S_SUB (1 cycle):
    - diff = sext(data[ch]) - sext(mean[ch]), computed in DW+1 bits.
    - Store sign = diff < 0 and mag = |diff|.
    - Dividend = mag << FRAC, Q = DW+1+FRAC bits.
    - Start the divider. Go to S_DIV.
  - S_DIV (Q cycles): restoring divider produces one quotient bit per cycle, MSB first. On the last bit, go to S_STORE.
  - S_STORE (1 cycle):
    - res = sign ? -quot : quot, i.e. truncation toward zero.
    - Saturate res to [-2^(OW-1), 2^(OW-1)-1] and write it to o_norm[ch].
    - If ch == N_CH-1, go to S_OUT; otherwise ch++ and go to S_SUB.
  - S_OUT: o_valid = 1. Hold o_valid and o_norm stable until i_ready=1, then go to S_IDLE on that edge.
- Latency: accept edge to o_valid high = N_CH*(Q+2) cycles. With defaults this is 8*27 = 216.
- Throughput: o_ready=1 only in S_IDLE, so there is no overlap. The first accept is possible the cycle after the o_valid/i_ready handshake.
- o_norm updates channel by channel during processing. o_norm is only guaranteed consistent while o_valid=1.
- std == 0: the divider is bypassed. Result is 0 if diff == 0, otherwise the saturated value for the sign: 2^(OW-1)-1 or -2^(OW-1). Cycle count is unchanged.
- diff == 0 with non-zero std gives exactly 0, never -0 artefacts.
- Reset mid-operation: everything is aborted to reset values immediately; no partial result survives.
- i_valid while busy: ignored, not queued.

Optional Feature:
NORM_ROUND_EN
- Defined:
  - The divider computes one extra quotient bit (Q+1 cycles in S_DIV).
  - Magnitude is rounded half-up before sign application and saturation, so the result rounds half away from zero.
  - Latency becomes N_CH*(Q+3).
- Undefined: truncation toward zero as above.

Decomposition:
- Shared package norm_pkg:
  - State enum (S_IDLE, S_SUB, S_DIV, S_STORE, S_OUT).
  - Default parameter constants.
  - Default mean/std coefficient arrays for the glove sensors, used by the top level to drive i_mean/i_std.
  - Saturation helper function.
- Sub-module norm_divider: serial restoring unsigned divider parametrised on dividend/divisor width.
  - Ports: start, dividend, divisor, quotient, done.
  - The FSM in seq_normalizer drives it.

Test Plan:
All values use defaults.
- Unit case: data[c] = 0x04F6, mean = 0x0305, std = 0x01F1 on all channels -> o_norm all 0x0100, o_valid exactly 216 cycles after accept.
- Negative: data = 0x0114, mean = 0x0305, std = 0x01F1 -> 0xFF00. Also data = 0x0000, mean = 0x0000, std = 0x0005 -> 0x0000.
- Saturation and zero divisor:
  - diff = +0x7FFF, std = 1 -> 0x7FFF.
  - diff = -0x8000, std = 1 -> 0x8000.
  - std = 0 with diff = +3 -> 0x7FFF; with diff = -3 -> 0x8000; with diff = 0 -> 0x0000.
- Rounding (diff = 2, std = 3): 0x00AA without NORM_ROUND_EN, 0x00AB with it (latency 224). Same with diff = -2: 0xFF56 vs 0xFF55.
- Backpressure:
  - Hold i_ready = 0 for 10 cycles after o_valid -> o_valid and o_norm stable, o_ready = 0, i_valid pulses ignored.
  - i_ready = 1 -> S_IDLE next cycle; a new sample is accepted the following cycle.
- Reset mid-division: assert i_rst_n during S_DIV of channel 3 -> o_valid = 0, o_norm all 0, o_ready = 1 in the same cycle. A new sample after reset produces correct results with no carry-over.
